// File: rtl/mult3_pkg.sv
// Shared types and helpers for the round-robin shared 3x3 multiplier.
package mult3_pkg;

    localparam int OPW = 3;
    localparam int PW  = 6;

    typedef logic [OPW-1:0] operand_t;
    typedef logic [PW-1:0]  product_t;

    // Round-robin successor of ptr among n requesters.
    function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned n);
        return (ptr + 1) % n;
    endfunction

endpackage

// File: rtl/mult3_rr_arbiter_if.sv
// Request/response bundle between operand sources, the arbiter and the product consumer.
interface mult3_rr_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
);
    logic [NREQ-1:0]   req_valid;
    logic [3*NREQ-1:0] req_a;
    logic [3*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic [5:0]        rsp_p;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_ready;
    logic [7:0]        busy_cnt;

    // Arbiter side.
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_p, rsp_id, busy_cnt
    );

    // Requester/consumer side.
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_p, rsp_id, busy_cnt
    );
endinterface

// File: rtl/mult3x3_core.sv
// Purely combinational 3x3 unsigned multiplier; full 6-bit product.
module mult3x3_core
    import mult3_pkg::*;
(
    input  operand_t a,
    input  operand_t b,
    output product_t p
);
    assign p = product_t'(a) * product_t'(b);
endmodule

// File: rtl/mult3_rr_arbiter.sv
// Round-robin sharing of one 3x3 multiplier among NREQ requesters, with a
// single registered result slot and a saturating backpressure counter.
module mult3_rr_arbiter
    import mult3_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic              clk,
    input  logic              rst,
    mult3_rr_arbiter_if.slave bus
);

    logic [IDW-1:0]  rr_ptr_q,    rr_ptr_d;
    logic            rsp_valid_q, rsp_valid_d;
    product_t        rsp_p_q,     rsp_p_d;
    logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
    logic [7:0]      busy_cnt_q,  busy_cnt_d;

    logic            slot_free;
    logic            grant_any;
    logic            grant;
    logic [IDW-1:0]  grant_idx;
    logic [NREQ-1:0] req_ready_vec;
    operand_t        op_a, op_b;
    product_t        core_p;

    assign slot_free = !rsp_valid_q || bus.rsp_ready;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and a latch is never inferred.
        grant_any = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_any && bus.req_valid[(int'(rr_ptr_q) + k) % NREQ]) begin
                grant_any = 1'b1;
                grant_idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
            end
        end
    end

    // Reset suppresses the grant so nothing is accepted while it is held.
    assign grant = grant_any && slot_free && !rst;

    always_comb begin
        req_ready_vec = '0;
        if (grant) req_ready_vec[grant_idx] = 1'b1;
    end

    assign op_a = bus.req_a[int'(grant_idx)*OPW +: OPW];
    assign op_b = bus.req_b[int'(grant_idx)*OPW +: OPW];

    mult3x3_core u_core (
        .a (op_a),
        .b (op_b),
        .p (core_p)
    );

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_p_d     = rsp_p_q;
        rsp_id_d    = rsp_id_q;
        busy_cnt_d  = busy_cnt_q;

        if (grant) begin
            rsp_valid_d = 1'b1;
            rsp_p_d     = core_p;
            rsp_id_d    = grant_idx;
            rr_ptr_d    = IDW'(next_rr(32'(grant_idx), NREQ));
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (rsp_valid_q && !bus.rsp_ready && busy_cnt_q != 8'hFF)
            busy_cnt_d = busy_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (rst) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_p_q     <= '0;
            rsp_id_q    <= '0;
            busy_cnt_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_p_q     <= rsp_p_d;
            rsp_id_q    <= rsp_id_d;
            busy_cnt_q  <= busy_cnt_d;
        end
    end

    assign bus.req_ready = req_ready_vec;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_p     = rsp_p_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_mult3_rr_arbiter.sv
// Directed table-driven bench for mult3_rr_arbiter (NREQ=4, IDW=3).
module tb_mult3_rr_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 3;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    mult3_rr_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus_if ();

    mult3_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  valid;
        logic [11:0] a;
        logic [11:0] b;
        logic        rsp_ready;
        logic [3:0]  exp_ready;
        logic        exp_rsp_valid;
        logic [5:0]  exp_p;
        logic [2:0]  exp_id;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    endtask

    // Advance one clock; outputs are then sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] v, input logic [11:0] a, input logic [11:0] b, input logic rr);
        bus_if.req_valid = v;
        bus_if.req_a     = a;
        bus_if.req_b     = b;
        bus_if.rsp_ready = rr;
        #1;
    endtask

    task automatic check_rsp(input string tag, input logic v, input int p, input int id);
        check({tag, ".rsp_valid"}, int'(bus_if.rsp_valid), int'(v));
        check({tag, ".rsp_p"},     int'(bus_if.rsp_p),     p);
        check({tag, ".rsp_id"},    int'(bus_if.rsp_id),    id);
    endtask

    logic [11:0] a_rr, b_rr;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus_if.req_valid = '0;
        bus_if.req_a     = '0;
        bus_if.req_b     = '0;
        bus_if.rsp_ready = 1'b0;

        // Table: {valid, a={a3,a2,a1,a0}, b, rsp_ready, exp_ready, exp_valid, exp_p, exp_id}
        vecs[0] = '{4'b0001, {3'd0,3'd0,3'd0,3'd5}, {3'd0,3'd0,3'd0,3'd7}, 1'b1, 4'b0001, 1'b1, 6'd35, 3'd0};
        vecs[1] = '{4'b0010, {3'd0,3'd0,3'd0,3'd0}, {3'd0,3'd0,3'd6,3'd0}, 1'b1, 4'b0010, 1'b1, 6'd0,  3'd1};
        vecs[2] = '{4'b0100, {3'd0,3'd7,3'd0,3'd0}, {3'd0,3'd7,3'd0,3'd0}, 1'b1, 4'b0100, 1'b1, 6'd49, 3'd2};
        vecs[3] = '{4'b0001, {3'd0,3'd0,3'd0,3'd1}, {3'd0,3'd0,3'd0,3'd1}, 1'b1, 4'b0001, 1'b1, 6'd1,  3'd0};
        vecs[4] = '{4'b0000, {3'd0,3'd0,3'd0,3'd0}, {3'd0,3'd0,3'd0,3'd0}, 1'b1, 4'b0000, 1'b0, 6'd1,  3'd0};
        vecs[5] = '{4'b1001, {3'd3,3'd0,3'd0,3'd2}, {3'd4,3'd0,3'd0,3'd2}, 1'b1, 4'b1000, 1'b1, 6'd12, 3'd3};

        // Reset state, with requests present: req_ready must stay low.
        drive(4'b1111, '1, '1, 1'b1);
        check("rst.req_ready", int'(bus_if.req_ready), 0);
        tick();
        tick();
        check_rsp("rst", 1'b0, 0, 0);
        check("rst.busy_cnt", int'(bus_if.busy_cnt), 0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].valid, vecs[i].a, vecs[i].b, vecs[i].rsp_ready);
            check($sformatf("vec%0d.req_ready", i), int'(bus_if.req_ready), int'(vecs[i].exp_ready));
            tick();
            check_rsp($sformatf("vec%0d", i), vecs[i].exp_rsp_valid, int'(vecs[i].exp_p), int'(vecs[i].exp_id));
        end

        // Fairness: all valid, consumer ready, pointer at 0.
        a_rr = {3'd7, 3'd6, 3'd5, 3'd4};
        b_rr = {3'd7, 3'd7, 3'd7, 3'd7};
        for (int i = 0; i < 8; i++) begin
            drive(4'b1111, a_rr, b_rr, 1'b1);
            check($sformatf("rr%0d.req_ready", i), int'(bus_if.req_ready), 1 << (i % 4));
            tick();
            check_rsp($sformatf("rr%0d", i), 1'b1, ((i % 4) + 4) * 7, i % 4);
        end

        // Backpressure: grant requester 1 (5*6), then stall for 5 cycles.
        drive(4'b0010, {3'd0,3'd0,3'd5,3'd0}, {3'd0,3'd0,3'd6,3'd0}, 1'b1);
        check("bp.grant", int'(bus_if.req_ready), 4'b0010);
        tick();
        check_rsp("bp.first", 1'b1, 30, 1);
        for (int i = 0; i < 5; i++) begin
            drive(4'b1111, a_rr, b_rr, 1'b0);
            check($sformatf("bp%0d.req_ready", i), int'(bus_if.req_ready), 0);
            tick();
            check_rsp($sformatf("bp%0d", i), 1'b1, 30, 1);
        end
        check("bp.busy_cnt", int'(bus_if.busy_cnt), 5);
        // Release: drain and refill in the same edge; pointer is 2.
        drive(4'b1111, a_rr, b_rr, 1'b1);
        check("bp.release.req_ready", int'(bus_if.req_ready), 4'b0100);
        tick();
        check_rsp("bp.release", 1'b1, 42, 2);
        check("bp.busy_hold", int'(bus_if.busy_cnt), 5);

        // Pointer hold: grant 1 (pointer 3 -> searches 3,0,1), idle 3 cycles, then all valid.
        drive(4'b0010, a_rr, b_rr, 1'b1);
        check("hold.grant1", int'(bus_if.req_ready), 4'b0010);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(4'b0000, a_rr, b_rr, 1'b1);
            tick();
        end
        check_rsp("hold.idle", 1'b0, 35, 1);
        drive(4'b1111, a_rr, b_rr, 1'b1);
        check("hold.req_ready", int'(bus_if.req_ready), 4'b0100);
        tick();
        check_rsp("hold.rsp", 1'b1, 42, 2);

        // Reset with a pending result and a nonzero busy count.
        drive(4'b0000, a_rr, b_rr, 1'b0);
        tick();
        check("mid.busy_pre", int'(bus_if.busy_cnt), 6);
        rst = 1'b1;
        drive(4'b1111, a_rr, b_rr, 1'b1);
        check("mid.rst.req_ready", int'(bus_if.req_ready), 0);
        tick();
        rst = 1'b0;
        check_rsp("mid.rst", 1'b0, 0, 0);
        check("mid.rst.busy_cnt", int'(bus_if.busy_cnt), 0);
        drive(4'b1111, a_rr, b_rr, 1'b1);
        check("mid.req_ready", int'(bus_if.req_ready), 4'b0001);
        tick();
        check_rsp("mid.rsp", 1'b1, 28, 0);

        // busy_cnt saturation at 255 under prolonged backpressure.
        drive(4'b0000, a_rr, b_rr, 1'b0);
        for (int i = 0; i < 260; i++) tick();
        check("sat.busy_cnt", int'(bus_if.busy_cnt), 255);
        check_rsp("sat", 1'b1, 28, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
